// File: rtl/load_seq.sv
// Load sequencer: reads 1/2/4 bytes one per cycle from a byte memory, assembles them
// little-endian and returns the sign/zero-extended word with a one-cycle done pulse.
module load_seq (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [2:0]  k_q, k_d;
  logic        rd_q, rd_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [2:0]  last_k;
  logic [1:0]  lane;
  logic        bad_req;

  assign rdata_o = rdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    uns_d      = uns_q;
    k_d        = k_q;
    rd_d       = 1'b0;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    mem_rd_o   = 1'b0;
    mem_addr_o = 32'h0;

    case (size_q)
      2'b00:   last_k = 3'd0;
      2'b01:   last_k = 3'd1;
      default: last_k = 3'd3;
    endcase

    bad_req = (size_i == 2'b11) ||
              (size_i == 2'b01 && addr_i[0]) ||
              (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    // Byte returned for the previous strobe lands in lane k-1 (k already advanced).
    lane = k_q[1:0] - 2'd1;
    if (rd_q) asm_d[{lane, 3'b000} +: 8] = mem_rdata_i;

    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          addr_d = addr_i;
          size_d = size_i;
          uns_d  = uns_i;
          k_d    = 3'd0;
          if (bad_req) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = READ;
            err_d   = 1'b0;
          end
        end
      end
      READ: begin
        mem_rd_o   = 1'b1;
        mem_addr_o = addr_q + {29'h0, k_q};
        rd_d       = 1'b1;
        k_d        = k_q + 3'd1;
        if (k_q == last_k) state_d = WAIT;
      end
      WAIT: begin
        state_d = DONE;
        case (size_q)
          2'b00:   rdata_d = {{24{asm_d[7] & ~uns_q}}, asm_d[7:0]};
          2'b01:   rdata_d = {{16{asm_d[15] & ~uns_q}}, asm_d[15:0]};
          default: rdata_d = asm_d;
        endcase
      end
      DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      k_q     <= 3'd0;
      rd_q    <= 1'b0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_load_seq.sv
// Bench for load_seq: directed table, hand-written corner sequences and random loads
// compared against an arithmetic reference model over a 256-byte memory image.
module tb_load_seq;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic [31:0] addr_i;
  logic [1:0]  size_i;
  logic        uns_i;
  logic        ready_o, done_o, err_o, mem_rd_o;
  logic [31:0] rdata_o, mem_addr_o;
  logic [7:0]  mem_rdata_i = 8'h0;

  logic [7:0]  mem [0:255];
  int checks = 0;
  int failures = 0;

  load_seq dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .addr_i(addr_i),
    .size_i(size_i), .uns_i(uns_i), .ready_o(ready_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .mem_rd_o(mem_rd_o),
    .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Byte memory: data appears the cycle after the strobe.
  always @(posedge clk_i) begin
    if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o[7:0]];
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    logic [7:0] idx;
    idx = a[7:0];
    mem[idx] = v;
  endtask

  // Reference: what a load of this shape must return, from the ISA rules.
  task automatic model(input logic [31:0] a, input logic [1:0] s, input logic u,
                       output logic [31:0] rd, output logic er, output int n);
    logic [31:0] v;
    logic [31:0] ai;
    logic [7:0]  idx;
    er = (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
    n  = 1 << s;
    v  = 32'h0;
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        ai  = a + i;
        idx = ai[7:0];
        v   = v | ({24'h0, mem[idx]} << (8 * i));
      end
      if (!u && s != 2'b10 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    end
    rd = er ? 32'h0 : v;
  endtask

  task automatic run_txn(input string nm, input logic [31:0] a, input logic [1:0] s,
                         input logic u, input logic [31:0] exp_rd, input logic exp_err,
                         input int n, input int pulse_at);
    int lat;
    chk({nm, ".ready"}, {31'h0, ready_o}, 32'h1);
    req_i = 1'b1; addr_i = a; size_i = s; uns_i = u;
    step();
    req_i = 1'b0;
    addr_i = $urandom; size_i = 2'($urandom); uns_i = 1'($urandom);
    lat = exp_err ? 1 : n + 2;
    for (int c = 1; c <= lat; c++) begin
      req_i = (c == pulse_at);
      if (exp_err) begin
        chk({nm, ".err_done"}, {31'h0, done_o}, 32'h1);
        chk({nm, ".err_flag"}, {31'h0, err_o}, 32'h1);
        chk({nm, ".err_rdata"}, rdata_o, 32'h0);
        chk({nm, ".err_no_rd"}, {31'h0, mem_rd_o}, 32'h0);
      end else if (c <= n) begin
        chk($sformatf("%s.rd%0d", nm, c), {31'h0, mem_rd_o}, 32'h1);
        chk($sformatf("%s.addr%0d", nm, c), mem_addr_o, a + c - 1);
        chk($sformatf("%s.nodone%0d", nm, c), {31'h0, done_o}, 32'h0);
      end else if (c == n + 1) begin
        chk({nm, ".wait_rd"}, {31'h0, mem_rd_o}, 32'h0);
        chk({nm, ".wait_done"}, {31'h0, done_o}, 32'h0);
      end else begin
        chk({nm, ".done"}, {31'h0, done_o}, 32'h1);
        chk({nm, ".err"}, {31'h0, err_o}, 32'h0);
        chk({nm, ".rdata"}, rdata_o, exp_rd);
      end
      step();
    end
    req_i = 1'b0;
    chk({nm, ".idle_ready"}, {31'h0, ready_o}, 32'h1);
    chk({nm, ".pulse_len"}, {31'h0, done_o}, 32'h0);
    chk({nm, ".hold"}, rdata_o, exp_rd);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] bytes;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
  } vec_t;

  initial begin
    vec_t vecs [10];
    logic [31:0] a, erd;
    logic [1:0]  s;
    logic        u, eer;
    int          n, pulses;

    vecs[0] = '{"lb",      32'h10, 2'b00, 1'b0, 32'h00000080, 32'hFFFFFF80, 1'b0, 1};
    vecs[1] = '{"lbu",     32'h10, 2'b00, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 1};
    vecs[2] = '{"lh",      32'h12, 2'b01, 1'b0, 32'h00009234, 32'hFFFF9234, 1'b0, 2};
    vecs[3] = '{"lhu",     32'h12, 2'b01, 1'b1, 32'h00009234, 32'h00009234, 1'b0, 2};
    vecs[4] = '{"lw",      32'h20, 2'b10, 1'b0, 32'h44332211, 32'h44332211, 1'b0, 4};
    vecs[5] = '{"lw_mis",  32'h21, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, 4};
    vecs[6] = '{"rsvd",    32'h33, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 8};
    vecs[7] = '{"lh_mis",  32'h13, 2'b01, 1'b1, 32'h0,        32'h0,        1'b1, 2};
    vecs[8] = '{"lw_uns",  32'h40, 2'b10, 1'b1, 32'h80FF0102, 32'h80FF0102, 1'b0, 4};
    vecs[9] = '{"lb_pos",  32'h55, 2'b00, 1'b0, 32'h0000007F, 32'h0000007F, 1'b0, 1};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset_i = 1'b1; req_i = 1'b0; addr_i = 32'h0; size_i = 2'b00; uns_i = 1'b0;
    step();
    step();
    chk("rst.ready", {31'h0, ready_o}, 32'h1);
    chk("rst.done", {31'h0, done_o}, 32'h0);
    chk("rst.err", {31'h0, err_o}, 32'h0);
    chk("rst.rdata", rdata_o, 32'h0);
    chk("rst.mem_rd", {31'h0, mem_rd_o}, 32'h0);
    chk("rst.mem_addr", mem_addr_o, 32'h0);
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      if (!vecs[i].exp_err)
        for (int b = 0; b < 4; b++) poke(vecs[i].addr + b, vecs[i].bytes[8*b +: 8]);
      run_txn(vecs[i].name, vecs[i].addr, vecs[i].size, vecs[i].uns,
              vecs[i].exp_rd, vecs[i].exp_err, vecs[i].n, 0);
    end

    // Request pulsed while busy must be dropped, not queued.
    run_txn("lw_busy_req", 32'h20, 2'b10, 1'b0, 32'h44332211, 1'b0, 4, 2);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_o) pulses++;
      step();
    end
    chk("busy_req.no_extra_done", pulses, 0);

    // Reset in the middle of a word load.
    req_i = 1'b1; addr_i = 32'h20; size_i = 2'b10; uns_i = 1'b0;
    step();
    req_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("midrst.ready", {31'h0, ready_o}, 32'h1);
    chk("midrst.mem_rd", {31'h0, mem_rd_o}, 32'h0);
    chk("midrst.mem_addr", mem_addr_o, 32'h0);
    chk("midrst.rdata", rdata_o, 32'h0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (done_o) pulses++;
      step();
    end
    chk("midrst.no_done", pulses, 0);
    run_txn("midrst.lb", 32'h10, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 1, 0);

    for (int t = 0; t < 60; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      s = 2'($urandom_range(0, 3));
      u = 1'($urandom);
      for (int b = 0; b < 4; b++) poke(a + b, 8'($urandom));
      model(a, s, u, erd, eer, n);
      run_txn($sformatf("rnd%0d", t), a, s, u, erd, eer, n, 0);
      if ($urandom_range(0, 1) != 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_seq.md
# load_seq

Multi-cycle load sequencer that sits between the CPU's memory stage and an 8-bit-wide byte memory. It accepts one load request (byte, halfword or word, signed or unsigned), reads the required bytes one per cycle, and assembles them little-endian. It then applies sign or zero extension to 32 bits and returns the result with a one-cycle done pulse. It is the control layer that sequences and configures the byte-to-word sign-extension datapath for lb/lbu/lh/lhu/lw.

## Interface

Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  1  load request; sampled only when ready=1
- addr  input  32  byte address of the load
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- uns  input  1  1 = zero-extend, 0 = sign-extend (ignored for word)
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse; rdata/err valid this cycle
- err  output  1  alignment/size error flag, valid with done
- rdata  output  32  extended load result
- mem_rd  output  1  byte read strobe
- mem_addr  output  32  byte address presented with mem_rd
- mem_rdata  input  8  byte returned by memory one cycle after mem_rd

## Operation

- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Byte count N: 1 for byte, 2 for halfword, 4 for word.
- States: IDLE, READ, WAIT, DONE.
- IDLE:
  - ready=1.
  - On req=1, latch addr, size and uns, and clear the byte counter k.
  - If the request is misaligned or reserved, go to DONE with the error flag set.
  - Otherwise go to READ.
- Error conditions: size=11; halfword with addr[0]=1; word with addr[1:0]!=00.
- READ:
  - mem_rd=1 and mem_addr=latched addr+k.
  - k increments each cycle.
  - After issuing byte N-1, go to WAIT.
- Capture: mem_rdata is written into byte lane (k-1) of an internal 32-bit assembly register on every cycle following a mem_rd cycle. This covers the READ cycles after the first, plus the WAIT cycle.
- WAIT: mem_rd=0; capture the last byte; go to DONE.
- DONE:
  - done=1 for one cycle, then return to IDLE.
  - rdata is registered on entry to DONE.
- Extension rules (b0..b3 = bytes at addr..addr+3):
  - byte: {24{b0[7] & ~uns}}, b0
  - half: {16{b1[7] & ~uns}}, b1, b0
  - word: b3, b2, b1, b0
  - error: 32'h0, err=1
- rdata holds its value until the next DONE. err is valid only while done=1.
- req while ready=0 is ignored; it is not queued.
- Inputs addr/size/uns may change after acceptance without effect.
- Address increment wraps modulo 2^32.

## Timing

- Reset values:
  - state IDLE, ready=1
  - done=0, err=0, rdata=0
  - mem_rd=0, mem_addr=0
  - byte counter 0, assembly register 0
- Reset asserted mid-operation: at the next edge the block returns to IDLE with all outputs at reset values. No done pulse is produced for the aborted request. Late mem_rdata is discarded.
- Request accepted at cycle T (IDLE, req=1):
  - mem_rd high in cycles T+1 .. T+N, with mem_addr = addr, addr+1, … in those cycles.
  - WAIT at T+N+1.
  - done at T+N+2.
- Latency from acceptance to done: byte 3, half 4, word 6 cycles.
- Error request accepted at T: done=1 and err=1 at T+1, with no mem_rd cycle.
- Next request can be accepted at T+N+3 (normal) or T+2 (error).
- Throughput: at most one load in flight.

## Test plan

- lb signed: addr=0x10, mem[0x10]=0x80, uns=0, req at T:
  - mem_rd at T+1 with mem_addr=0x10.
  - done at T+3 with rdata=0xFFFFFF80, err=0.
- lbu: same stimulus with uns=1 → rdata=0x00000080 at T+3.
- lh / lhu: addr=0x12, mem[0x12]=0x34, mem[0x13]=0x92:
  - lh (uns=0) → rdata=0xFFFF9234 at T+4.
  - lhu (uns=1) → rdata=0x00009234 at T+4.
- lw: addr=0x20, bytes 0x11, 0x22, 0x33, 0x44:
  - mem_addr sequence 0x20..0x23 in cycles T+1..T+4.
  - rdata=0x44332211 at T+6.
  - A req pulsed at T+2 is ignored and yields no extra done.
- Misaligned and reserved requests:
  - lw at addr=0x21 → done=1, err=1, rdata=0 at T+1, and mem_rd never asserts.
  - size=11 at any address → same response.
- Reset mid-word: lw accepted at T, reset=1 at T+2 → at T+3 state is IDLE, ready=1, mem_rd=0, rdata=0, and done never pulses. A fresh lb then completes normally in 3 cycles.
